fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the fetch stage: owns the PC, drives the instruction-memory read port and presents the fetched word to the IF/ID buffer.
- On reset, loads the start PC from a 32-bit reset vector stored in instruction memory. Interrupts load their target from a 32-bit interrupt vector the same way.
- Arbitrates between sequential fetch, taken jumps, pipeline stall and interrupt entry. Sits between the hazard/branch logic and the instruction memory.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 16, instruction word width.
- RESET_VEC_ADDR, 0, word address of reset vector high half; the low half is at +1.
- INT_VEC_ADDR, 2, word address of interrupt vector high half; the low half is at +1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID outputs (hazard unit).
- jump_taken  in  1  redirect fetch to jump_address.
- jump_address  in  32  jump target (word address).
- int_req  in  1  level interrupt request.
- mem_rdata  in  16  instruction memory read data, combinational from mem_addr.
- mem_addr  out  32  instruction memory address (combinational from state/PC).
- mem_cs  out  1  memory chip select.
- pc  out  32  address of the instruction being fetched.
- next_pc  out  32  pc+1, combinational.
- instr  out  16  fetched instruction to IF/ID.
- instr_valid  out  1  instr holds a real instruction (0 = bubble).
- saved_pc  out  32  return PC captured at interrupt entry.
- int_ack  out  1  one-cycle pulse on interrupt acceptance.

Behaviour:
- Reset (async, rst_n=0): state=BOOT_HI, pc=0, instr=0, instr_valid=0, saved_pc=0, int_ack=0, vec_hi=0, mem_cs=0. Outputs hold these values while reset is asserted.
- After reset: mem_cs=1 every cycle.
- mem_addr is driven as follows:
  - BOOT_HI: RESET_VEC_ADDR.
  - BOOT_LO: RESET_VEC_ADDR+1.
  - INT_HI: INT_VEC_ADDR.
  - INT_LO: INT_VEC_ADDR+1.
  - RUN: pc.
- BOOT_HI: vec_hi<=mem_rdata; go to BOOT_LO. stall, jump_taken and int_req are ignored.
- BOOT_LO: pc<={vec_hi,mem_rdata}; go to RUN. instr_valid stays 0. The first valid instr appears 3 cycles after reset release.
- RUN, priority jump_taken > int_req > stall > sequential:
  - jump_taken: pc<=jump_address, instr<=0, instr_valid<=0 (one bubble). stall is overridden.
  - int_req (no jump): saved_pc<=pc, int_ack<=1 for one cycle, instr<=0, instr_valid<=0; go to INT_HI. An interrupt accepted under stall=1 is still taken.
  - stall only: pc, instr and instr_valid hold.
  - otherwise: instr<=mem_rdata, instr_valid<=1, pc<=pc+1.
- INT_HI: vec_hi<=mem_rdata; go to INT_LO. int_ack<=0.
- INT_LO: pc<={vec_hi,mem_rdata}; go to RUN.
- INT_HI and INT_LO ignore stall and jump_taken. instr_valid is 0 throughout.
- int_req is level-sensitive and is not sampled outside RUN. If int_req is still high on return to RUN, it is taken again; the source must deassert on int_ack.
- jump_taken together with int_req: the jump wins and the interrupt is taken the next RUN cycle, so saved_pc = jump_address.
- pc+1 and next_pc wrap modulo 2^32: 0xFFFFFFFF -> 0x00000000.
- Reset asserted mid-sequence (any state) returns immediately to reset values; the boot sequence restarts.
- No combinational path from stall, jump_taken or int_req to mem_addr; mem_addr depends only on state and pc.

Test Plan:
- Boot: M[0]=0x0000, M[1]=0x0020, M[0x20..0x22]=0xA001,0xA002,0xA003; release rst_n -> instr_valid=0 for 2 cycles, then pc=0x20; the following edges give instr 0xA001/0xA002/0xA003 with pc 0x21/0x22/0x23.
- Stall: in RUN at pc=0x22, stall=1 for 3 cycles -> pc=0x22, instr and instr_valid frozen; release -> fetch resumes at 0x22 with no word lost or duplicated.
- Jump: pc=0x23, jump_taken=1 with jump_address=0x100 and stall=1 -> next cycle pc=0x100, instr_valid=0; the next cycle gives instr=M[0x100] and instr_valid=1.
- Interrupt: M[2]=0x0000, M[3]=0x0200; int_req=1 at pc=0x30 -> int_ack one pulse, saved_pc=0x30; 2 cycles later pc=0x200; instr_valid=0 throughout entry. Also: jump_taken and int_req in the same cycle (jump_address=0x40) -> saved_pc=0x40.
- Wrap: jump to 0xFFFFFFFF -> after one sequential fetch, pc=0x00000000 and next_pc=0x00000001.
- Mid-run reset: assert rst_n=0 asynchronously during INT_LO -> all outputs at reset values without waiting for a clock edge; release -> full boot sequence from RESET_VEC_ADDR again.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction-memory port,
// and the PC / IF-ID outputs. The sequencer is the master.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall;
    logic                   jump_taken;
    logic [ADDR_WIDTH-1:0]  jump_address;
    logic                   int_req;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_cs;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic [ADDR_WIDTH-1:0]  saved_pc;
    logic                   int_ack;

    modport master (
        input  stall, jump_taken, jump_address, int_req, mem_rdata,
        output mem_addr, mem_cs, pc, next_pc, instr, instr_valid,
               saved_pc, int_ack
    );

    modport slave (
        output stall, jump_taken, jump_address, int_req, mem_rdata,
        input  mem_addr, mem_cs, pc, next_pc, instr, instr_valid,
               saved_pc, int_ack
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: boots the PC from the reset vector, then fetches
// sequentially, honouring jumps, stalls and interrupt entry (which loads
// the PC from the interrupt vector in two half-word reads).
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    INSTR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VEC_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] INT_VEC_ADDR   = ADDR_WIDTH'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        BOOT_HI,
        BOOT_LO,
        RUN,
        INT_HI,
        INT_LO
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0]  saved_pc_q, saved_pc_d;
    logic                   int_ack_q, int_ack_d;
    logic [INSTR_WIDTH-1:0] vec_hi_q, vec_hi_d;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic [ADDR_WIDTH-1:0]  vec_full;

    // Incremented PC wraps naturally at 2^ADDR_WIDTH.
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    // Vector = previously captured high half joined with the word read now.
    assign vec_full = ADDR_WIDTH'({vec_hi_q, bus.mem_rdata});

    // State and datapath registers.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT_HI;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            saved_pc_q    <= '0;
            int_ack_q     <= 1'b0;
            vec_hi_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            saved_pc_q    <= saved_pc_d;
            int_ack_q     <= int_ack_d;
            vec_hi_q      <= vec_hi_d;
        end
    end

    // Next-state logic; RUN priority is jump > interrupt > stall > fetch.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        saved_pc_d    = saved_pc_q;
        int_ack_d     = 1'b0;
        vec_hi_d      = vec_hi_q;

        unique case (state_q)
            BOOT_HI: begin
                vec_hi_d = bus.mem_rdata;
                state_d  = BOOT_LO;
            end
            BOOT_LO: begin
                pc_d          = vec_full;
                instr_valid_d = 1'b0;
                state_d       = RUN;
            end
            RUN: begin
                if (bus.jump_taken) begin
                    pc_d          = bus.jump_address;
                    instr_d       = '0;
                    instr_valid_d = 1'b0;
                end else if (bus.int_req) begin
                    saved_pc_d    = pc_q;
                    int_ack_d     = 1'b1;
                    instr_d       = '0;
                    instr_valid_d = 1'b0;
                    state_d       = INT_HI;
                end else if (!bus.stall) begin
                    instr_d       = bus.mem_rdata;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_inc;
                end
            end
            INT_HI: begin
                vec_hi_d      = bus.mem_rdata;
                instr_valid_d = 1'b0;
                state_d       = INT_LO;
            end
            INT_LO: begin
                pc_d          = vec_full;
                instr_valid_d = 1'b0;
                state_d       = RUN;
            end
            default: state_d = BOOT_HI;
        endcase
    end

    // Memory address depends only on state and PC, never on control inputs.
    always_comb begin
        bus.mem_addr = pc_q;
        unique case (state_q)
            BOOT_HI: bus.mem_addr = RESET_VEC_ADDR;
            BOOT_LO: bus.mem_addr = RESET_VEC_ADDR + ADDR_WIDTH'(1);
            INT_HI:  bus.mem_addr = INT_VEC_ADDR;
            INT_LO:  bus.mem_addr = INT_VEC_ADDR + ADDR_WIDTH'(1);
            default: bus.mem_addr = pc_q;
        endcase
    end

    // Chip select follows reset directly: low while held in reset, high on
    // every cycle after release, including the very first boot read.
    assign bus.mem_cs      = rst_n;
    assign bus.pc          = pc_q;
    assign bus.next_pc     = pc_inc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.saved_pc    = saved_pc_q;
    assign bus.int_ack     = int_ack_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table walks boot, stall,
// jump, interrupt entry and PC wrap; hand-written sequences cover reset
// at power-up and asynchronous reset in the middle of interrupt entry.
module tb_fetch_sequencer;
    logic clk;
    logic rst_n;

    fetch_sequencer_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(16)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH    (32),
        .INSTR_WIDTH   (16),
        .RESET_VEC_ADDR(32'h0),
        .INT_VEC_ADDR  (32'h2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: 1K words, pattern beyond that range.
    logic [15:0] mem [0:1023];
    always_comb begin
        if (bus.mem_addr < 32'd1024) bus.mem_rdata = mem[bus.mem_addr[9:0]];
        else                         bus.mem_rdata = bus.mem_addr[15:0] ^ 16'hC3C3;
    end

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic        irq;
        logic [31:0] e_pc;
        logic [15:0] e_instr;
        logic        e_valid;
        logic        e_ack;
        logic [31:0] e_saved;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [15:0] e_instr,
                             input logic e_valid, input logic e_ack, input logic [31:0] e_saved,
                             input logic [31:0] e_maddr, input logic e_cs);
        check({tag, " pc"},       bus.pc, e_pc);
        check({tag, " next_pc"},  bus.next_pc, e_pc + 32'd1);
        check({tag, " instr"},    32'(bus.instr), 32'(e_instr));
        check({tag, " valid"},    32'(bus.instr_valid), 32'(e_valid));
        check({tag, " int_ack"},  32'(bus.int_ack), 32'(e_ack));
        check({tag, " saved_pc"}, bus.saved_pc, e_saved);
        check({tag, " mem_addr"}, bus.mem_addr, e_maddr);
        check({tag, " mem_cs"},   32'(bus.mem_cs), 32'(e_cs));
    endtask

    task automatic drive(input logic s, input logic j, input logic [31:0] a, input logic r);
        bus.stall        = s;
        bus.jump_taken   = j;
        bus.jump_address = a;
        bus.int_req      = r;
    endtask

    task automatic step(input logic s, input logic j, input logic [31:0] a, input logic r);
        drive(s, j, a, r);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic j, input logic [31:0] a, input logic r,
                       input logic [31:0] pc, input logic [15:0] ins, input logic v,
                       input logic ack, input logic [31:0] sv, input logic [31:0] ma);
        vec_t t;
        t.stall = s;  t.jump = j;  t.jaddr = a;  t.irq = r;
        t.e_pc = pc;  t.e_instr = ins;  t.e_valid = v;
        t.e_ack = ack;  t.e_saved = sv;  t.e_maddr = ma;
        vecs.push_back(t);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hB000 | 16'(i);
        mem[0]     = 16'h0000;  mem[1]     = 16'h0020;
        mem[2]     = 16'h0000;  mem[3]     = 16'h0200;
        mem[32'h20] = 16'hA001; mem[32'h21] = 16'hA002; mem[32'h22] = 16'hA003;

        //   stall jump jaddr          irq  pc             instr     v  ack saved        mem_addr
        add(0, 0, 32'h0,        0, 32'h0,        16'h0,    0, 0, 32'h0,  32'h1);        // boot hi
        add(0, 0, 32'h0,        0, 32'h20,       16'h0,    0, 0, 32'h0,  32'h20);       // boot lo
        add(0, 0, 32'h0,        0, 32'h21,       16'hA001, 1, 0, 32'h0,  32'h21);
        add(0, 0, 32'h0,        0, 32'h22,       16'hA002, 1, 0, 32'h0,  32'h22);
        add(1, 0, 32'h0,        0, 32'h22,       16'hA002, 1, 0, 32'h0,  32'h22);       // stall x3
        add(1, 0, 32'h0,        0, 32'h22,       16'hA002, 1, 0, 32'h0,  32'h22);
        add(1, 0, 32'h0,        0, 32'h22,       16'hA002, 1, 0, 32'h0,  32'h22);
        add(0, 0, 32'h0,        0, 32'h23,       16'hA003, 1, 0, 32'h0,  32'h23);       // resume
        add(1, 1, 32'h100,      0, 32'h100,      16'h0,    0, 0, 32'h0,  32'h100);      // jump over stall
        add(0, 0, 32'h0,        0, 32'h101,      16'hB100, 1, 0, 32'h0,  32'h101);
        add(0, 1, 32'h30,       0, 32'h30,       16'h0,    0, 0, 32'h0,  32'h30);
        add(0, 0, 32'h0,        1, 32'h30,       16'h0,    0, 1, 32'h30, 32'h2);        // int accept
        add(0, 0, 32'h0,        0, 32'h30,       16'h0,    0, 0, 32'h30, 32'h3);        // int hi
        add(0, 0, 32'h0,        0, 32'h200,      16'h0,    0, 0, 32'h30, 32'h200);      // int lo
        add(0, 0, 32'h0,        0, 32'h201,      16'hB200, 1, 0, 32'h30, 32'h201);
        add(0, 1, 32'h40,       1, 32'h40,       16'h0,    0, 0, 32'h30, 32'h40);       // jump beats int
        add(0, 0, 32'h0,        1, 32'h40,       16'h0,    0, 1, 32'h40, 32'h2);        // int next cycle
        add(1, 1, 32'h999,      1, 32'h40,       16'h0,    0, 0, 32'h40, 32'h3);        // ignored in INT_HI
        add(0, 0, 32'h0,        0, 32'h200,      16'h0,    0, 0, 32'h40, 32'h200);
        add(0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 16'h0,    0, 0, 32'h40, 32'hFFFFFFFF); // wrap
        add(0, 0, 32'h0,        0, 32'h0,        16'h3C3C, 1, 0, 32'h40, 32'h0);
        add(0, 0, 32'h0,        0, 32'h1,        16'h0000, 1, 0, 32'h40, 32'h1);
        add(0, 0, 32'h0,        1, 32'h1,        16'h0,    0, 1, 32'h1,  32'h2);        // int again
        add(0, 0, 32'h0,        0, 32'h1,        16'h0,    0, 0, 32'h1,  32'h3);        // now in INT_LO

        // Power-up reset: outputs at reset values before and across an edge.
        rst_n = 1'b0;
        drive(1, 1, 32'h55, 1);
        #2;
        check_all("reset", 32'h0, 16'h0, 0, 0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        check_all("reset_edge", 32'h0, 16'h0, 0, 0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].jump, vecs[i].jaddr, vecs[i].irq);
            check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid,
                      vecs[i].e_ack, vecs[i].e_saved, vecs[i].e_maddr, 1);
        end

        // Asynchronous reset during INT_LO: takes effect without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("midrst", 32'h0, 16'h0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check_all("midrst_hold", 32'h0, 16'h0, 0, 0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;
        step(0, 0, 32'h0, 0);
        check_all("reboot_hi", 32'h0, 16'h0, 0, 0, 32'h0, 32'h1, 1);
        step(0, 0, 32'h0, 0);
        check_all("reboot_lo", 32'h20, 16'h0, 0, 0, 32'h0, 32'h20, 1);
        step(0, 0, 32'h0, 0);
        check_all("reboot_run", 32'h21, 16'hA001, 1, 0, 32'h0, 32'h21, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
